// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state encoding and memory op codes for mem_access_ctrl
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_rd_latency_pipe.sv
// rtl/mem_rd_latency_pipe.sv - delays the read-issue strobe by LATENCY cycles so it marks
// the cycle in which mem_data_out holds the read word (LATENCY=0 is a passthrough)
module mem_rd_latency_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic strobe_o
);

  if (LATENCY == 0) begin : g_pass
    assign strobe_o = strobe_i;
  end else begin : g_shift
    logic [LATENCY-1:0] shift_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        shift_q <= '0;
      end else begin
        shift_q <= (shift_q << 1) | LATENCY'(strobe_i);
      end
    end

    assign strobe_o = shift_q[LATENCY-1];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - request/response front end driving memory_unit cycles: single writes,
// wrapping read bursts; optional write readback check under MEM_ACCESS_CTRL_VERIFY_EN
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW           = 3,
  parameter int unsigned DW           = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_last,
  output logic          verify_err,
  output logic          mem_select,
  output logic          mem_op,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, len_q, len_d, beat_q, beat_d;
  logic          mem_select_q, mem_select_d, mem_op_q, mem_op_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_in_q, mem_data_in_d;
  logic          resp_valid_q, resp_valid_d, resp_last_q, resp_last_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          rd_issued, cap;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  logic [DW-1:0] wdata_q;
  logic          verify_err_q, verify_err_d;
`endif

  assign rd_issued = mem_select_q && (mem_op_q == MEM_OP_READ);

  mem_rd_latency_pipe #(.LATENCY(READ_LATENCY)) u_lat_pipe (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (rd_issued),
    .strobe_o (cap)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_d       = beat_q;
    mem_select_d = 1'b0;
    mem_op_d     = MEM_OP_READ;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_last_d  = resp_last_q;
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    verify_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d       = req_addr;
        len_d        = req_len;
        beat_d       = '0;
        mem_select_d = 1'b1;
        mem_op_d     = req_write ? MEM_OP_WRITE : MEM_OP_READ;
        state_d      = req_write ? WRITE : RD_ISSUE;
      end
      WRITE: begin
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
        mem_select_d = 1'b1;
        state_d      = VERIFY;
`else
        state_d      = IDLE;
`endif
      end
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
      VERIFY: if (cap) begin
        verify_err_d = (mem_data_out != wdata_q);
        state_d      = IDLE;
      end
`endif
      RD_ISSUE, RD_WAIT: begin
        if (cap) begin
          resp_valid_d = 1'b1;
          resp_data_d  = mem_data_out;
          resp_last_d  = (beat_q == len_q);
          state_d      = RESP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        resp_last_d  = 1'b0;
        if (beat_q == len_q) begin
          state_d = IDLE;
        end else begin
          addr_d       = addr_q + AW'(1);
          beat_d       = beat_q + AW'(1);
          mem_select_d = 1'b1;
          state_d      = RD_ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Address/data lines are driven only while selected so the bus idles at zero.
    mem_addr_d    = mem_select_d ? addr_d : '0;
    mem_data_in_d = (mem_select_d && mem_op_d == MEM_OP_WRITE) ? req_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      mem_select_q  <= 1'b0;
      mem_op_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      mem_select_q  <= mem_select_d;
      mem_op_q      <= mem_op_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_last_q   <= resp_last_d;
    end
  end

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q      <= '0;
      verify_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) wdata_q <= req_wdata;
      verify_err_q <= verify_err_d;
    end
  end
  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

  assign req_ready   = (state_q == IDLE) && !rst;
  assign mem_select  = mem_select_q;
  assign mem_op      = mem_op_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_last   = resp_last_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with a registered-read memory model
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0] req_addr = '0, req_len = '0;
  logic [7:0] req_wdata = '0;
  logic       resp_valid, resp_ready = 1'b1, resp_last, verify_err;
  logic [7:0] resp_data;
  logic       mem_select, mem_op;
  logic [2:0] mem_addr;
  logic [7:0] mem_data_in, mem_data_out;

  logic [7:0] mem [8];
  logic [7:0] rd_q;
  logic       corrupt3 = 1'b0;

  int total = 0, bad = 0;
  int beats_seen = 0, vfy_pulses = 0;
  logic [8:0]  exp_q[$];
  logic [10:0] wr_q[$];
  logic [2:0]  rd_addr_q[$];

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [2:0]  len;
    logic [7:0]  wdata;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .verify_err(verify_err),
    .mem_select(mem_select), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // memory_unit model: one-cycle registered read, optional corruption of word 3 on readback
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'hA0 + 8'(i);
      rd_q <= 8'h00;
    end else if (mem_select) begin
      if (mem_op) mem[mem_addr] <= mem_data_in;
      else rd_q <= (corrupt3 && mem_addr == 3'd3) ? (mem[mem_addr] ^ 8'hFF) : mem[mem_addr];
    end
  end
  assign mem_data_out = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    logic [10:0] w;
    logic [8:0]  e;
    if (mem_select && mem_op) begin
      if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w[10:8]));
        chk("wr_data", 32'(mem_data_in), 32'(w[7:0]));
      end
    end
    if (mem_select && !mem_op) begin
      if (rd_addr_q.size() == 0) chk("unexpected_read", 1, 0);
      else chk("rd_addr", 32'(mem_addr), 32'(rd_addr_q.pop_front()));
      chk("rd_data_in_zero", 32'(mem_data_in), 0);
    end
    if (resp_valid && resp_ready) begin
      beats_seen++;
      if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("resp_data", 32'(resp_data), 32'(e[7:0]));
        chk("resp_last", 32'(resp_last), 32'(e[8]));
      end
    end
    if (verify_err) vfy_pulses++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [2:0] a, input logic [2:0] len,
                        input logic [7:0] d, input logic [63:0] exp);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    chk("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len; req_wdata = d;
    if (wr) begin
      wr_q.push_back({a, d});
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
      rd_addr_q.push_back(a);
`endif
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        rd_addr_q.push_back(a + 3'(i));
        exp_q.push_back({(i == int'(len)), exp[8*(7-i) +: 8]});
      end
    end
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 3'($urandom); req_len = 3'($urandom); req_wdata = 8'($urandom);
    if (wr) begin
      n = 0;
      while (!req_ready && n < 10) begin tick(); n++; end
`ifdef MEM_ACCESS_CTRL_VERIFY_EN
      chk("write_to_ready", n, 3);
`else
      chk("write_to_ready", n, 1);
`endif
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0 || rd_addr_q.size() != 0 || !req_ready) && n < 200) begin
      tick(); n++;
    end
    chk("drain_timeout", (n < 200), 1);
    tick();
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 3'd0, 3'd0, 8'h6D, 64'h0};
    tbl[1] = '{1'b1, 3'd1, 3'd0, 8'h6F, 64'h0};
    tbl[2] = '{1'b1, 3'd2, 3'd0, 8'h72, 64'h0};
    tbl[3] = '{1'b1, 3'd3, 3'd0, 8'h74, 64'h0};
    tbl[4] = '{1'b1, 3'd4, 3'd0, 8'h65, 64'h0};
    tbl[5] = '{1'b1, 3'd5, 3'd0, 8'h6E, 64'h0};
    tbl[6] = '{1'b0, 3'd0, 3'd5, 8'h00, 64'h6D6F7274656E0000};
    tbl[7] = '{1'b0, 3'd6, 3'd3, 8'h00, 64'hA6A76D6F00000000};
    tbl[8] = '{1'b0, 3'd7, 3'd0, 8'h00, 64'hA700000000000000};
    tbl[9] = '{1'b0, 3'd2, 3'd7, 8'h00, 64'h7274656EA6A76D6F};

    // reset state
    tick(); tick(); tick();
    chk("rst_mem_select", 32'(mem_select), 0);
    chk("rst_mem_op", 32'(mem_op), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data_in", 32'(mem_data_in), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_resp_last", 32'(resp_last), 0);
    chk("rst_verify_err", 32'(verify_err), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst = 1'b0;
    #1;
    chk("req_ready_after_rst", 32'(req_ready), 1);

    for (int i = 0; i < 10; i++) do_req(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].wdata, tbl[i].exp);
    drain();

    // backpressure on beat 2
    beats_seen = 0;
    do_req(1'b0, 3'd0, 3'd3, 8'h00, 64'h6D6F727400000000);
    n = 0;
    while (!(beats_seen == 2 && resp_valid) && n < 50) begin tick(); n++; end
    chk("stall_reach_beat2", (n < 50), 1);
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(resp_valid), 1);
      chk("stall_data", 32'(resp_data), 32'h72);
      chk("stall_no_select", 32'(mem_select), 0);
    end
    resp_ready = 1'b1;
    drain();

    // reset mid-burst
    beats_seen = 0;
    do_req(1'b0, 3'd0, 3'd5, 8'h00, 64'h6D6F7274656E0000);
    n = 0;
    while (beats_seen < 1 && n < 50) begin tick(); n++; end
    chk("rst_reach_beat1", (n < 50), 1);
    rst = 1'b1;
    tick();
    chk("abort_mem_select", 32'(mem_select), 0);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    chk("abort_req_ready", 32'(req_ready), 0);
    exp_q.delete(); rd_addr_q.delete(); wr_q.delete();
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 32'(req_ready), 1);
    tick();

`ifdef MEM_ACCESS_CTRL_VERIFY_EN
    corrupt3 = 1'b1;
    vfy_pulses = 0;
    do_req(1'b1, 3'd3, 3'd0, 8'h74, 64'h0);
    drain();
    chk("verify_err_bad_word", vfy_pulses, 1);
    do_req(1'b1, 3'd2, 3'd0, 8'h55, 64'h0);
    drain();
    chk("verify_err_good_word", vfy_pulses, 1);
`else
    do_req(1'b1, 3'd3, 3'd0, 8'h74, 64'h0);
    drain();
    chk("verify_err_quiet", vfy_pulses, 0);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
